sram_access_ctrl: RTL and testbench

//  Request-driven sequencer that generates the async-SRAM pin protocol for the 16-bit external memory.

---
 rtl/sram_access_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
//   Request-driven sequencer that produces the asynchronous-SRAM pin protocol
//   for a 16-bit external memory. The host side accepts one request at a time
//   through valid/ready. Each request is answered with a one-cycle ack, and a
//   read also returns its data with rd_valid.
//
//   Sequence per bus cycle: IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> HOLD (1)
//   -> IDLE. A request with no byte lane enabled is acked one cycle later and
//   never touches the bus. Every pin output is a register. The next-state logic
//   computes each pin value for the state that is being entered.
//
// Parameters
//   ADDR_W       word-address width
//   DATA_W       data width, split into two byte lanes (lb/ub)
//   WAIT_CYCLES  clocks spent in ACCESS (1..15; 0 behaves as 1)
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              host handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata/req_be request fields; be = {ub,lb}, active high
//   ack, rd_valid, rd_data           completion pulse, read-data pulse, read data
//   sram_ce_n, sram_ce2, sram_we_n,
//   sram_oe_n, sram_lb_n, sram_ub_n,
//   sram_addr, sram_wdata,
//   sram_wdata_oe                    SRAM pins and data-bus drive enable
//   sram_rdata                       data returned by the SRAM
//   stat_rd_cnt, stat_wr_cnt         saturating counts of acked reads and writes
//
// Configuration
//   SRAM_ACCESS_CTRL_STATS_EN        when defined, the stat_* counters are
//                                    implemented. Otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_ce_n,
  output logic              sram_ce2,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int HALF_W   = DATA_W / 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic                op_we_q, op_we_d;
  logic [1:0]          be_q, be_d;
  logic                req_ready_q, req_ready_d;
  logic                ack_q, ack_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ce_n_q, ce_n_d;
  logic                ce2_q, ce2_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wdata_oe_q, wdata_oe_d;
  logic [DATA_W-1:0]   lane_mask;

  // A disabled byte lane is not driven by the SRAM, so it reads back as zero.
  assign lane_mask = {{HALF_W{be_q[1]}}, {HALF_W{be_q[0]}}};

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    op_we_d    = op_we_q;
    be_d       = be_q;
    ack_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    ce_n_d     = ce_n_q;
    ce2_d      = ce2_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    lb_n_d     = lb_n_q;
    ub_n_d     = ub_n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wdata_oe_d = wdata_oe_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_be == 2'b00) begin
            // Nothing to transfer: complete at once and leave the bus quiet.
            ack_d = 1'b1;
            if (!req_we) begin
              rd_valid_d = 1'b1;
              rd_data_d  = '0;
            end
          end else begin
            state_d    = SETUP;
            op_we_d    = req_we;
            be_d       = req_be;
            addr_d     = req_addr;
            if (req_we) wdata_d = req_wdata;
            ce_n_d     = 1'b0;
            ce2_d      = 1'b1;
            lb_n_d     = ~req_be[0];
            ub_n_d     = ~req_be[1];
            wdata_oe_d = req_we;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = WAIT_LOAD;
        if (op_we_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d     = 1'b0;
          wdata_oe_d = 1'b0;
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          // Last ACCESS edge: capture read data, then strobes go high for HOLD.
          // Chip enable, address and data stay where they are.
          state_d = HOLD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack_d   = 1'b1;
          if (!op_we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = sram_rdata & lane_mask;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HOLD: begin
        state_d    = IDLE;
        ce_n_d     = 1'b1;
        ce2_d      = 1'b0;
        lb_n_d     = 1'b1;
        ub_n_d     = 1'b1;
        wdata_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      op_we_q     <= 1'b0;
      be_q        <= 2'b00;
      req_ready_q <= 1'b0;
      ack_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      ce_n_q      <= 1'b1;
      ce2_q       <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wdata_oe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      op_we_q     <= op_we_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      ack_q       <= ack_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      ce_n_q      <= ce_n_d;
      ce2_q       <= ce2_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wdata_oe_q  <= wdata_oe_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign ack           = ack_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_ce2      = ce2_q;
  assign sram_we_n     = we_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_lb_n     = lb_n_q;
  assign sram_ub_n     = ub_n_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_wdata_oe = wdata_oe_q;

`ifdef SRAM_ACCESS_CTRL_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Counts follow the ack decision, so requests with no lanes enabled are counted too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else if (ack_d) begin
      if (rd_valid_d) begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end else begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_wr_cnt = wr_cnt_q;
`else
  assign stat_rd_cnt = 16'h0000;
  assign stat_wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_access_ctrl
//   Bench for sram_access_ctrl with WAIT_CYCLES=2. A behavioural 256-word SRAM
//   model is attached; addresses alias on their low 8 bits. The model starts out
//   holding init_word(i) at each address. The bench checks reset, a read sweep,
//   a table of directed requests with hand-computed results, reset during a
//   write, and be==00 requests.
// -----------------------------------------------------------------------------
module tb_sram_access_ctrl;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = 2'b00;
  logic          ack, rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_ce_n, sram_ce2, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          sram_wdata_oe;
  logic [15:0]   stat_rd_cnt, stat_wr_cnt;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .ack(ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_ce_n(sram_ce_n), .sram_ce2(sram_ce2), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
    .sram_rdata(sram_rdata),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 257) ^ 16'hC35A;
  endfunction

  // SRAM model: initialised on the first clock, written on any edge with we_n low.
  // When not output-enabled it returns a marker, so sampling read data at the wrong time shows up.
  logic [15:0] mem [0:255];
  logic        init_done = 1'b0;
  assign sram_rdata = (!sram_ce_n && sram_ce2 && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (!sram_ce_n && sram_ce2 && !sram_we_n && sram_wdata_oe) begin
      mem[sram_addr[7:0]] <= {sram_ub_n ? mem[sram_addr[7:0]][15:8] : sram_wdata[15:8],
                              sram_lb_n ? mem[sram_addr[7:0]][7:0]  : sram_wdata[7:0]};
    end
  end

  int overlap_cnt = 0;
  int ncyc = 0;
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!sram_we_n && !sram_oe_n) overlap_cnt <= overlap_cnt + 1;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;   // rd_data after the request (held value for writes)
  } vec_t;

  vec_t vecs [14];

  // Issue one request and watch the five cycles after acceptance:
  // index 0 = SETUP, 1..WC = ACCESS, WC+1 = HOLD, WC+2 = IDLE again.
  task automatic run_req(input vec_t v, input string tag);
    int ack_idx, ack_n, rdv_n, we_lo, oe_lo, ce_lo, ub_lo, lb_lo;
    logic [15:0] rd_at_ack;
    logic bus;
    bus = (v.be != 2'b00);
    ack_idx = -1; ack_n = 0; rdv_n = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; ub_lo = 0; lb_lo = 0;
    rd_at_ack = 16'h0;
    @(negedge clk);
    check({tag, ".ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < WC + 3; i++) begin
      @(negedge clk);
      if (ack) begin
        ack_n++;
        if (ack_idx < 0) ack_idx = i;
        rd_at_ack = rd_data;
      end
      if (rd_valid) rdv_n++;
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n) ce_lo++;
      if (!sram_ub_n) ub_lo++;
      if (!sram_lb_n) lb_lo++;
      if (i == 0 && bus) begin
        check({tag, ".setup_addr"}, 32'(sram_addr), 32'(v.addr));
        check({tag, ".setup_strobes"}, 32'({sram_we_n, sram_oe_n, sram_ce2}), 32'(3'b111));
        check({tag, ".setup_wdata_oe"}, 32'(sram_wdata_oe), 32'(v.we));
        if (v.we) check({tag, ".setup_wdata"}, 32'(sram_wdata), 32'(v.wdata));
      end
    end
    check({tag, ".ack_at"}, 32'(ack_idx), bus ? 32'(WC + 1) : 32'd0);
    check({tag, ".ack_count"}, 32'(ack_n), 32'd1);
    check({tag, ".rd_valid_count"}, 32'(rdv_n), v.we ? 32'd0 : 32'd1);
    check({tag, ".we_low"}, 32'(we_lo), (bus && v.we) ? 32'(WC) : 32'd0);
    check({tag, ".oe_low"}, 32'(oe_lo), (bus && !v.we) ? 32'(WC) : 32'd0);
    check({tag, ".ce_low"}, 32'(ce_lo), bus ? 32'(WC + 2) : 32'd0);
    check({tag, ".ub_low"}, 32'(ub_lo), (bus && v.be[1]) ? 32'(WC + 2) : 32'd0);
    check({tag, ".lb_low"}, 32'(lb_lo), (bus && v.be[0]) ? 32'(WC + 2) : 32'd0);
    if (!v.we) check({tag, ".rd_at_ack"}, 32'(rd_at_ack), 32'(v.exp_rd));
    check({tag, ".rd_data_after"}, 32'(rd_data), 32'(v.exp_rd));
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int waited, last, acks;
    logic [15:0] rd_before;
    vec_t rv;

    //            we    addr        wdata     be     rd_data afterwards
    vecs[0]  = '{1'b1, 22'h00000F, 16'hA5A5, 2'b11, 16'h3CA5};  // rd_data still from sweep (addr 255)
    vecs[1]  = '{1'b0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5};
    vecs[2]  = '{1'b0, 22'h00000F, 16'h0000, 2'b01, 16'h00A5};
    vecs[3]  = '{1'b0, 22'h00000F, 16'h0000, 2'b10, 16'hA500};
    vecs[4]  = '{1'b1, 22'h000010, 16'hFFFF, 2'b11, 16'hA500};
    vecs[5]  = '{1'b1, 22'h000010, 16'h1234, 2'b01, 16'hA500};
    vecs[6]  = '{1'b0, 22'h000010, 16'h0000, 2'b11, 16'hFF34};
    vecs[7]  = '{1'b1, 22'h000010, 16'hABCD, 2'b10, 16'hFF34};
    vecs[8]  = '{1'b0, 22'h000010, 16'h0000, 2'b11, 16'hAB34};
    vecs[9]  = '{1'b1, 22'h3FFFFF, 16'h5555, 2'b11, 16'hAB34};
    vecs[10] = '{1'b0, 22'h3FFFFF, 16'h0000, 2'b11, 16'h5555};
    vecs[11] = '{1'b0, 22'h00000F, 16'h0000, 2'b00, 16'h0000};
    vecs[12] = '{1'b1, 22'h00000F, 16'h0000, 2'b00, 16'h0000};
    vecs[13] = '{1'b0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5};

    // Reset state, checked while reset is asserted.
    #12;
    check("rst.pins", 32'({sram_ce_n, sram_ce2, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_wdata_oe}),
          32'(7'b1011110));
    check("rst.addr", 32'(sram_addr), 32'd0);
    check("rst.wdata", 32'(sram_wdata), 32'd0);
    check("rst.ack_rdv", 32'({ack, rd_valid}), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready_after_release", 32'(req_ready), 32'd1);
    check("rst.ce_n_after_release", 32'(sram_ce_n), 32'd1);

    // Read sweep with valid held high: every read matches the initial contents,
    // and consecutive acceptances are WC+3 cycles apart.
    req_we = 1'b0; req_be = 2'b11; last = -1;
    for (int a = 0; a < 256; a++) begin
      req_addr = 22'(a);
      req_valid = 1'b1;
      waited = 0;
      while (!req_ready && waited < 12) begin
        @(negedge clk);
        waited++;
      end
      if (!req_ready) begin
        check("sweep.ready_timeout", 32'd0, 32'd1);
        break;
      end
      if (last >= 0) check("sweep.spacing", 32'(ncyc - last), 32'(WC + 3));
      last = ncyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!ack && waited < 12) begin
        @(negedge clk);
        waited++;
      end
      check("sweep.ack", 32'(ack), 32'd1);
      check("sweep.rd_data", 32'(rd_data), 32'(init_word(a)));
    end

    // Directed request table.
    for (int i = 0; i < 14; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // be==00 read: the stats counter (when built in) still counts it.
    rd_before = stat_rd_cnt;
    rv = '{1'b0, 22'h000020, 16'h0000, 2'b00, 16'h0000};
    run_req(rv, "be00_rd");
`ifdef SRAM_ACCESS_CTRL_STATS_EN
    check("stats.rd_incr", 32'(stat_rd_cnt), 32'(rd_before + 16'd1));
`else
    check("stats.rd_tied", 32'(stat_rd_cnt), 32'(rd_before & 16'h0000));
    check("stats.wr_tied", 32'(stat_wr_cnt), 32'd0);
`endif

    // Reset asserted in the middle of a write's ACCESS phase. The data written
    // is what the location already holds, so the following read expects it whatever happens.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 22'h00000F; req_wdata = 16'hA5A5; req_be = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);            // SETUP
    @(negedge clk);            // first ACCESS cycle
    check("rstw.in_access_we_n", 32'(sram_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw.pins_now", 32'({sram_ce_n, sram_ce2, sram_we_n, sram_oe_n, sram_wdata_oe}), 32'(5'b10110));
    check("rstw.ack_now", 32'(ack), 32'd0);
    check("rstw.ready_now", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rstw.no_ack", 32'(acks), 32'd0);
    rv = '{1'b0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5};
    run_req(rv, "rstw_read");

    check("we_oe_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
